// File: rtl/ball_x_ctrl_if.sv
// Signal bundle between the rally controller and the ball-X position stage / player inputs.
// master = controller side, slave = X stage and player input side.
interface ball_x_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             go;
    logic [WIDTH-1:0] xpos;
    logic             hit_l;
    logic             hit_r;
    logic             step;
    logic             dir;
    logic             recentre;
    logic [3:0]       score_l;
    logic [3:0]       score_r;
    logic [1:0]       state;
    logic [1:0]       winner;
    logic             err;

    modport master (
        input  go, xpos, hit_l, hit_r,
        output step, dir, recentre, score_l, score_r, state, winner, err
    );

    modport slave (
        output go, xpos, hit_l, hit_r,
        input  step, dir, recentre, score_l, score_r, state, winner, err
    );
endinterface

// File: rtl/ball_x_ctrl.sv
// Rally controller for the one-hot ball-X stage: step pacing, edge bounce/miss resolution,
// scoring and serve/pause/game-over sequencing. All outputs are registered.
module ball_x_ctrl #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned STEP_DIV  = 2_500_000,
    parameter int unsigned PAUSE_CYC = 50_000_000,
    parameter int unsigned SCORE_MAX = 9
) (
    input logic           clocke,
    input logic           SorR,
    ball_x_ctrl_if.master bus
);
    localparam int unsigned TickW  = $clog2(STEP_DIV);
    localparam int unsigned PauseW = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;

    localparam logic [TickW-1:0]  TickLast  = TickW'(STEP_DIV - 1);
    localparam logic [PauseW-1:0] PauseLast = PauseW'(PAUSE_CYC - 1);
    localparam logic [3:0]        ScoreMax  = 4'(SCORE_MAX);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StPlay  = 2'b01,
        StPause = 2'b10,
        StOver  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic              dir_q, dir_d;
    logic              step_q, step_d;
    logic              recentre_q, recentre_d;
    logic [3:0]        score_l_q, score_l_d;
    logic [3:0]        score_r_q, score_r_d;
    logic [1:0]        winner_q, winner_d;
    logic              err_q, err_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [PauseW-1:0] pause_q, pause_d;
    logic              go_q;

    logic go_edge;
    logic xpos_onehot;
    logic at_left;
    logic at_right;

    assign go_edge     = bus.go & ~go_q;
    assign xpos_onehot = (bus.xpos != '0) && ((bus.xpos & (bus.xpos - WIDTH'(1))) == '0);
    assign at_left     = ~dir_q & bus.xpos[0];
    assign at_right    = dir_q & bus.xpos[WIDTH-1];

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        step_d     = 1'b0;
        recentre_d = 1'b0;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        winner_d   = winner_q;
        err_d      = err_q;
        tick_d     = tick_q;
        pause_d    = pause_q;

        unique case (state_q)
            StIdle: begin
                tick_d  = '0;
                pause_d = '0;
                if (go_edge) begin
                    state_d = StPlay;
                end
            end

            StPlay: begin
                pause_d = '0;
                if (tick_q == TickLast) begin
                    tick_d = '0;
                    if (!xpos_onehot) begin
                        err_d      = 1'b1;
                        recentre_d = 1'b1;
                    end else if (at_left) begin
                        if (bus.hit_l) begin
                            // New direction and step land on the same edge for the X stage.
                            dir_d  = 1'b1;
                            step_d = 1'b1;
                        end else begin
                            if (score_r_q < ScoreMax) begin
                                score_r_d = score_r_q + 4'd1;
                            end
                            dir_d      = 1'b1;
                            recentre_d = 1'b1;
                            state_d    = StPause;
                        end
                    end else if (at_right) begin
                        if (bus.hit_r) begin
                            dir_d  = 1'b0;
                            step_d = 1'b1;
                        end else begin
                            if (score_l_q < ScoreMax) begin
                                score_l_d = score_l_q + 4'd1;
                            end
                            dir_d      = 1'b0;
                            recentre_d = 1'b1;
                            state_d    = StPause;
                        end
                    end else begin
                        step_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end

            StPause: begin
                tick_d = '0;
                if (pause_q == PauseLast) begin
                    pause_d = '0;
                    if (score_l_q == ScoreMax) begin
                        winner_d = 2'b01;
                        state_d  = StOver;
                    end else if (score_r_q == ScoreMax) begin
                        winner_d = 2'b10;
                        state_d  = StOver;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    pause_d = pause_q + PauseW'(1);
                end
            end

            StOver: begin
                tick_d  = '0;
                pause_d = '0;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // go_q resets high so a button held through reset does not count as a serve.
    always_ff @(posedge clocke) begin
        if (SorR) begin
            state_q    <= StIdle;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            recentre_q <= 1'b0;
            score_l_q  <= 4'd0;
            score_r_q  <= 4'd0;
            winner_q   <= 2'b00;
            err_q      <= 1'b0;
            tick_q     <= '0;
            pause_q    <= '0;
            go_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            recentre_q <= recentre_d;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
            winner_q   <= winner_d;
            err_q      <= err_d;
            tick_q     <= tick_d;
            pause_q    <= pause_d;
            go_q       <= bus.go;
        end
    end

    assign bus.step     = step_q;
    assign bus.dir      = dir_q;
    assign bus.recentre = recentre_q;
    assign bus.score_l  = score_l_q;
    assign bus.score_r  = score_r_q;
    assign bus.state    = state_q;
    assign bus.winner   = winner_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_ball_x_ctrl.sv
// Directed bench for ball_x_ctrl with short step/pause periods and a 3-point game.
module tb_ball_x_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    ball_x_ctrl_if #(.WIDTH(16)) bus ();

    ball_x_ctrl #(
        .WIDTH    (16),
        .STEP_DIV (4),
        .PAUSE_CYC(8),
        .SCORE_MAX(3)
    ) dut (
        .clocke(clk),
        .SorR  (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic serve();
        bus.go = 1'b0;
        cyc(1);
        bus.go = 1'b1;
        cyc(1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.go    = 1'b0;
        bus.xpos  = 16'h0100;
        bus.hit_l = 1'b0;
        bus.hit_r = 1'b0;

        // Reset state
        cyc(2);
        chk("rst_state", bus.state, 2'b00);
        chk("rst_dir", bus.dir, 1'b0);
        chk("rst_step", bus.step, 1'b0);
        chk("rst_recentre", bus.recentre, 1'b0);
        chk("rst_scores", {bus.score_l, bus.score_r}, 8'h00);
        chk("rst_winner", bus.winner, 2'b00);
        chk("rst_err", bus.err, 1'b0);
        rst = 1'b0;
        cyc(1);

        // 1: serve, steps every 4th cycle
        bus.go = 1'b1;
        cyc(1);
        chk("t1_play", bus.state, 2'b01);
        cyc(3);
        chk("t1_nostep", bus.step, 1'b0);
        cyc(1);
        chk("t1_step", bus.step, 1'b1);
        chk("t1_dir", bus.dir, 1'b0);
        cyc(1);
        chk("t1_pulse", bus.step, 1'b0);
        cyc(2);
        chk("t1_nostep2", bus.step, 1'b0);
        cyc(1);
        chk("t1_step2", bus.step, 1'b1);

        // 2: left paddle bounce, then right paddle bounce
        bus.xpos  = 16'h0001;
        bus.hit_l = 1'b1;
        cyc(4);
        chk("t2_step", bus.step, 1'b1);
        chk("t2_dir", bus.dir, 1'b1);
        chk("t2_scores", {bus.score_l, bus.score_r}, 8'h00);
        bus.hit_l = 1'b0;
        bus.xpos  = 16'h8000;
        bus.hit_r = 1'b1;
        cyc(4);
        chk("t2_rstep", bus.step, 1'b1);
        chk("t2_rdir", bus.dir, 1'b0);
        bus.hit_r = 1'b0;

        // 3: left miss, pause, go ignored during pause
        bus.xpos = 16'h0001;
        cyc(4);
        chk("t3_step", bus.step, 1'b0);
        chk("t3_score_r", bus.score_r, 4'd1);
        chk("t3_state", bus.state, 2'b10);
        chk("t3_recentre", bus.recentre, 1'b1);
        chk("t3_dir", bus.dir, 1'b1);
        bus.go = 1'b0;
        cyc(1);
        chk("t3_recentre_off", bus.recentre, 1'b0);
        bus.go = 1'b1;
        cyc(6);
        chk("t3_still_pause", bus.state, 2'b10);
        cyc(1);
        chk("t3_idle", bus.state, 2'b00);
        chk("t3_dir_after", bus.dir, 1'b1);
        cyc(2);
        chk("t3_go_ignored", bus.state, 2'b00);

        // Right miss gives left a point
        bus.xpos = 16'h0100;
        serve();
        chk("lp_play", bus.state, 2'b01);
        bus.xpos = 16'h8000;
        cyc(4);
        chk("lp_score_l", bus.score_l, 4'd1);
        chk("lp_state", bus.state, 2'b10);
        chk("lp_dir", bus.dir, 1'b0);
        cyc(8);
        chk("lp_idle", bus.state, 2'b00);

        // 4: right player reaches 3
        serve();
        bus.xpos = 16'h0001;
        cyc(4);
        chk("t4_score_r2", bus.score_r, 4'd2);
        cyc(8);
        chk("t4_idle", bus.state, 2'b00);
        serve();
        bus.xpos  = 16'h8000;
        bus.hit_r = 1'b1;
        cyc(4);
        chk("t4_bounce", {bus.step, bus.dir}, 2'b10);
        bus.hit_r = 1'b0;
        bus.xpos  = 16'h0001;
        cyc(4);
        chk("t4_score_r3", bus.score_r, 4'd3);
        cyc(7);
        chk("t4_pause_end", bus.state, 2'b10);
        cyc(1);
        chk("t4_over", bus.state, 2'b11);
        chk("t4_winner", bus.winner, 2'b10);
        serve();
        cyc(4);
        chk("t4_go_ignored", bus.state, 2'b11);
        chk("t4_frozen", {bus.score_l, bus.score_r, bus.step}, 9'h026);
        rst = 1'b1;
        cyc(1);
        chk("t4_rst", {bus.state, bus.winner, bus.score_l, bus.score_r, bus.dir}, 13'h0);

        // 5: go held through reset release
        bus.go = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(3);
        chk("t5_held", bus.state, 2'b00);
        serve();
        chk("t5_play", bus.state, 2'b01);

        // 6: non-one-hot xpos at tick
        bus.xpos = 16'h0000;
        cyc(3);
        chk("t6_err_pre", bus.err, 1'b0);
        cyc(1);
        chk("t6_err", bus.err, 1'b1);
        chk("t6_recentre", bus.recentre, 1'b1);
        chk("t6_nostep", bus.step, 1'b0);
        chk("t6_state", {bus.state, bus.dir}, 3'b010);
        bus.xpos = 16'h0003;
        cyc(1);
        chk("t6_rc_off", bus.recentre, 1'b0);
        cyc(3);
        chk("t6_multi", {bus.err, bus.recentre, bus.step}, 3'b110);
        bus.xpos = 16'h0040;
        cyc(4);
        chk("t6_sticky", {bus.err, bus.recentre, bus.step}, 3'b101);

        // 7: reset coincident with a tick
        cyc(3);
        rst = 1'b1;
        cyc(1);
        chk("t7_rst", {bus.step, bus.recentre, bus.err, bus.state}, 5'b0);
        chk("t7_scores", {bus.score_l, bus.score_r}, 8'h00);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
